// File: rtl/ecc_pkg.sv
// Shared constants and types for the ECC arithmetic blocks.
// Holds the default operand width and the inverter's state encoding.
package ecc_pkg;

  localparam int N = 231;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } invState_e;

endpackage

// File: rtl/modular_inverter_if.sv
// Request/response bundle for the modular inverter.
// The requester owns start/A/p; the inverter owns the result and status.
interface modular_inverter_if import ecc_pkg::*; #(
  parameter int n = N
) ();

  logic         start;
  logic [n-1:0] A;
  logic [n-1:0] p;
  logic [n-1:0] X;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start, A, p,
    input  X, busy, done, err
  );

  modport slave (
    input  start, A, p,
    output X, busy, done, err
  );

endinterface

// File: rtl/modular_halver.sv
// Computes x/2 mod p for an odd modulus p and x in [0, p-1].
// Odd x gets p added first so the division by two is exact.
module modular_halver import ecc_pkg::*; #(
  parameter int n = N
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] p,
  output logic [n-1:0] half
);

  logic [n:0] sum;

  // The extra top bit keeps x+p from wrapping before the shift.
  assign sum  = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
  assign half = n'(sum >> 1);

endmodule

// File: rtl/modular_inverter.sv
// Binary extended-Euclid inverter: X = A^-1 mod p for an odd prime p.
// One reduction step per RUN cycle, with a watchdog against non-prime moduli.
module modular_inverter import ecc_pkg::*; #(
  parameter int n = N
) (
  input  logic             clk,
  input  logic             reset,
  modular_inverter_if.slave bus
);

  localparam int WD_LIMIT = 4 * n + 2;
  localparam int WD_W     = $clog2(4 * n + 3);

  invState_e state_q, state_d;

  logic [n-1:0]    u_q, u_d;
  logic [n-1:0]    v_q, v_d;
  logic [n-1:0]    x1_q, x1_d;
  logic [n-1:0]    x2_q, x2_d;
  logic [n-1:0]    p_q, p_d;
  logic [n-1:0]    X_q, X_d;
  logic            err_q, err_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic [n-1:0] x1Half;
  logic [n-1:0] x2Half;
  logic         badOperand;
  logic         uIsOne;
  logic         vIsOne;
  logic         wdExpired;
  logic         busy;
  logic         done;

  function automatic logic [n-1:0] modSub(input logic [n-1:0] a,
                                          input logic [n-1:0] b,
                                          input logic [n-1:0] m);
    logic [n:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (a < b) diff = diff + {1'b0, m};
    return n'(diff);
  endfunction

  modular_halver #(.n(n)) halveX1 (.x(x1_q), .p(p_q), .half(x1Half));
  modular_halver #(.n(n)) halveX2 (.x(x2_q), .p(p_q), .half(x2Half));

  assign badOperand = (bus.A == '0) || (bus.A >= bus.p);
  assign uIsOne     = (u_q == n'(1));
  assign vIsOne     = (v_q == n'(1));
  assign wdExpired  = (wd_q >= WD_W'(WD_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = badOperand ? FINISH : RUN;
      RUN:     if (uIsOne || vIsOne || wdExpired) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FINISH);
  end

  // Termination is tested before the watchdog so a legitimate result is never discarded.
  always_comb begin
    u_d   = u_q;
    v_d   = v_q;
    x1_d  = x1_q;
    x2_d  = x2_q;
    p_d   = p_q;
    X_d   = X_q;
    err_d = err_q;
    wd_d  = wd_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          p_d   = bus.p;
          u_d   = bus.A;
          v_d   = bus.p;
          x1_d  = n'(1);
          x2_d  = '0;
          wd_d  = '0;
          X_d   = '0;
          err_d = badOperand;
        end
      end
      RUN: begin
        if (uIsOne) begin
          X_d = x1_q;
        end else if (vIsOne) begin
          X_d = x2_q;
        end else if (wdExpired) begin
          X_d   = '0;
          err_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = x1Half;
          end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = x2Half;
          end else if (u_q >= v_q) begin
            u_d  = u_q - v_q;
            x1_d = modSub(x1_q, x2_q, p_q);
          end else begin
            v_d  = v_q - u_q;
            x2_d = modSub(x2_q, x1_q, p_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      u_q   <= '0;
      v_q   <= '0;
      x1_q  <= '0;
      x2_q  <= '0;
      p_q   <= '0;
      X_q   <= '0;
      err_q <= 1'b0;
      wd_q  <= '0;
    end else begin
      u_q   <= u_d;
      v_q   <= v_d;
      x1_q  <= x1_d;
      x2_q  <= x2_d;
      p_q   <= p_d;
      X_q   <= X_d;
      err_q <= err_d;
      wd_q  <= wd_d;
    end
  end

  assign bus.X    = X_q;
  assign bus.err  = err_q;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: doc/modular_inverter.md
MODULAR_INVERTER -- requirements
Module: modular_inverter

Interface
REQ-001 Parameter: n, default 231, operand/modulus width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  n  operand to invert; captured on accepted start.
REQ-006 p  input  n  modulus, odd prime; captured on accepted start.
REQ-007 X  output  n  result A^-1 mod p; valid when done=1, held until next accepted start.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  A not invertible (A==0 or A>=p); valid with done, held with X.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-012 IDLE + start=1 SHALL capture A and p, clear err, set busy=1 next cycle, and load u=A, v=p, x1=1, x2=0.
REQ-013 IDLE + start=1 + (A==0 or A>=p) SHALL skip RUN, go to FINISH, and set err=1 and X=0.
REQ-014 IDLE + start=0 SHALL hold every register.
REQ-015 Each RUN cycle SHALL first check termination: u==1 -> X<=x1 and go to FINISH; else v==1 -> X<=x2 and go to FINISH.
REQ-016 Otherwise, each RUN cycle SHALL perform exactly one step, by priority: u even -> u>>=1, x1<=half(x1); else v even -> v>>=1, x2<=half(x2); else u>=v -> u<=u-v, x1<=(x1-x2) mod p; else v<=v-u, x2<=(x2-x1) mod p.
REQ-017 half(x) SHALL be x>>1 for even x and (x+p)>>1 for odd x, computed in n+1 bits with no overflow.
REQ-018 Modular subtraction SHALL be a-b if a>=b, else a-b+p; x1 and x2 SHALL always stay in [0,p-1].
REQ-019 FINISH SHALL last one cycle: done=1, busy=0, then IDLE.
REQ-020 busy SHALL be 1 in every RUN cycle and 0 in IDLE and FINISH.
REQ-021 Latency from start cycle to done SHALL be k+2 cycles, where k is the number of RUN step cycles; k SHALL be at most 4n.
REQ-022 A==1 SHALL terminate on the first RUN cycle (k=0), giving done 2 cycles after start with X=1.
REQ-023 start asserted while busy or in FINISH SHALL be ignored, with no capture and no effect.
REQ-024 Changes on A or p after capture SHALL NOT affect the running computation.
REQ-025 A RUN-cycle watchdog exceeding 4n+2 cycles SHALL force FINISH with err=1 and X=0 (non-prime p protection).

Reset
REQ-026 reset=1 SHALL force IDLE, X=0, busy=0, done=0, err=0, and clear u, v, x1, x2 and the watchdog counter.
REQ-027 reset SHALL take priority over start and over any RUN/FINISH activity; a reset mid-operation SHALL abort it with no done pulse.
REQ-028 The first start accepted after reset deasserts SHALL behave identically to one issued after power-up reset.

Structure
REQ-029 A shared package ecc_pkg SHALL hold the default width constant N=231 and the inverter state enum (IDLE, RUN, FINISH).
REQ-030 One sub-module, modular_halver (inputs x, p; output half(x)), SHALL be instantiated twice, once for x1 and once for x2.
REQ-031 Datapath registers SHALL be n bits wide; intermediate sums SHALL be n+1 bits; the watchdog counter SHALL be clog2(4n+3) bits wide.

Verification (n=8, p=251 unless stated)
REQ-032 Basic inversion: A=3, start pulse -> single done pulse, X=84, err=0; 3*84 mod 251 = 1.
REQ-033 Inverse of 2 and of p-1: A=2 -> X=126; A=250 -> X=250; done pulse count is 1 per start.
REQ-034 Early exit: A=1 -> done exactly 2 cycles after start, X=1; A=0 -> done 1 cycle after start, err=1, X=0; A=251 -> err=1.
REQ-035 Reset mid-run: start A=3, assert reset on 3rd RUN cycle -> busy=0, no done; then start A=5 -> X=201 (5*201 mod 251 = 1).
REQ-036 Robustness: start re-pulsed and A changed while busy -> ignored, result still matches the first captured A; exhaustive sweep A=1..250 -> A*X mod 251 == 1 with k<=32 every time.
